// File: rtl/expr_pkg.sv
// Shared constants and types for the expression front end.
// The tokenizer and the downstream converter both import these.
package expr_pkg;

  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_9      = 8'h39;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_EQUALS = 8'h3D;

  localparam int         ACC_W   = 12;
  localparam logic [11:0] ACC_MAX = 12'd255;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    EMIT_NUM,
    EMIT_SIGN,
    FINISH
  } state_t;

  typedef enum logic [2:0] {
    CLS_DIGIT,
    CLS_SIGN,
    CLS_SPACE,
    CLS_TERM,
    CLS_INVALID
  } char_class_t;

  // The terminator is checked first so a TERM_CHAR overlapping a sign still ends the expression.
  function automatic char_class_t classify(input logic [7:0] c, input logic [7:0] term);
    char_class_t cls;
    if (c == term)
      cls = CLS_TERM;
    else if (c >= CH_0 && c <= CH_9)
      cls = CLS_DIGIT;
    else if (c == CH_PLUS || c == CH_MINUS || c == CH_STAR || c == CH_SLASH ||
             c == CH_LPAREN || c == CH_RPAREN)
      cls = CLS_SIGN;
    else if (c == CH_SPACE)
      cls = CLS_SPACE;
    else
      cls = CLS_INVALID;
    return cls;
  endfunction

endpackage

// File: rtl/expr_tokenizer_if.sv
// Character input and token output handshakes of the expression tokenizer.
// master is the tokenizer side, slave is the source/sink side.
interface expr_tokenizer_if;
  logic [7:0] CHAR_IN;
  logic       CHAR_STB;
  logic       CHAR_ACK;
  logic [7:0] SIGN_OUT;
  logic       SIGN_STB;
  logic       SIGN_ACK;
  logic [7:0] NUMBER_OUT;
  logic       NUMBER_STB;
  logic       NUMBER_ACK;

  modport master (
    input  CHAR_IN, CHAR_STB, SIGN_ACK, NUMBER_ACK,
    output CHAR_ACK, SIGN_OUT, SIGN_STB, NUMBER_OUT, NUMBER_STB
  );

  modport slave (
    output CHAR_IN, CHAR_STB, SIGN_ACK, NUMBER_ACK,
    input  CHAR_ACK, SIGN_OUT, SIGN_STB, NUMBER_OUT, NUMBER_STB
  );
endinterface

// File: rtl/expr_tokenizer.sv
// Splits an ASCII arithmetic expression into unsigned number tokens and sign tokens.
// Characters are only consumed in IDLE/ACCUM; emit states stall the input until acknowledged.
module expr_tokenizer
  import expr_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = CH_EQUALS
) (
  input  logic              CLK,
  input  logic              RST,
  expr_tokenizer_if.master  bus,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR
);

  state_t      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        error_q, error_d;
  logic        number_stb_q, number_stb_d;
  logic [7:0]  number_out_q, number_out_d;
  logic        sign_stb_q, sign_stb_d;
  logic [7:0]  sign_out_q, sign_out_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic             char_take;
  char_class_t      cls;
  logic [ACC_W-1:0] digit_val;
  logic [ACC_W-1:0] acc_wide;

  always_comb begin
    char_take = bus.CHAR_STB && (state_q == IDLE || state_q == ACCUM);
    cls       = classify(bus.CHAR_IN, TERM_CHAR);
    digit_val = {4'd0, bus.CHAR_IN} - {4'd0, CH_0};
    acc_wide  = ({4'd0, acc_q} * 12'd10) + digit_val;
  end

  assign bus.CHAR_ACK = char_take && !RST;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    error_d    = error_q;

    unique case (state_q)
      IDLE: begin
        if (char_take) begin
          unique case (cls)
            CLS_DIGIT: begin
              acc_d   = digit_val[7:0];
              state_d = ACCUM;
            end
            CLS_SIGN, CLS_TERM: begin
              pend_d     = bus.CHAR_IN;
              pend_vld_d = 1'b1;
              state_d    = EMIT_SIGN;
            end
            CLS_SPACE: ;
            default: error_d = 1'b1;
          endcase
        end
      end

      ACCUM: begin
        if (char_take) begin
          unique case (cls)
            CLS_DIGIT: begin
              // Overflow saturates rather than wrapping so the error stays visible in the value.
              if (acc_wide > ACC_MAX) begin
                acc_d   = ACC_MAX[7:0];
                error_d = 1'b1;
              end else begin
                acc_d = acc_wide[7:0];
              end
            end
            CLS_SPACE: begin
              pend_vld_d = 1'b0;
              state_d    = EMIT_NUM;
            end
            CLS_SIGN, CLS_TERM: begin
              pend_d     = bus.CHAR_IN;
              pend_vld_d = 1'b1;
              state_d    = EMIT_NUM;
            end
            default: error_d = 1'b1;
          endcase
        end
      end

      EMIT_NUM: begin
        if (bus.NUMBER_ACK)
          state_d = pend_vld_q ? EMIT_SIGN : IDLE;
      end

      EMIT_SIGN: begin
        if (bus.SIGN_ACK) begin
          state_d    = (pend_q == TERM_CHAR) ? FINISH : IDLE;
          pend_vld_d = 1'b0;
          pend_d     = 8'd0;
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    number_stb_d = (state_d == EMIT_NUM);
    number_out_d = number_stb_d ? acc_d : 8'd0;
    sign_stb_d   = (state_d == EMIT_SIGN);
    sign_out_d   = sign_stb_d ? pend_d : 8'd0;
    done_d       = (state_d == FINISH);
    busy_d       = (state_d == EMIT_NUM) || (state_d == EMIT_SIGN) || (state_d == FINISH);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      acc_q        <= 8'd0;
      pend_q       <= 8'd0;
      pend_vld_q   <= 1'b0;
      error_q      <= 1'b0;
      number_stb_q <= 1'b0;
      number_out_q <= 8'd0;
      sign_stb_q   <= 1'b0;
      sign_out_q   <= 8'd0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      error_q      <= error_d;
      number_stb_q <= number_stb_d;
      number_out_q <= number_out_d;
      sign_stb_q   <= sign_stb_d;
      sign_out_q   <= sign_out_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.NUMBER_STB = number_stb_q;
  assign bus.NUMBER_OUT = number_out_q;
  assign bus.SIGN_STB   = sign_stb_q;
  assign bus.SIGN_OUT   = sign_out_q;
  assign DONE           = done_q;
  assign BUSY           = busy_q;
  assign ERROR          = error_q;

endmodule

// File: tb/tb_expr_tokenizer.sv
// Directed testbench for expr_tokenizer: feeds expression strings and compares
// the emitted token stream, DONE pulses and ERROR against hand-derived expectations.
module tb_expr_tokenizer;

  logic CLK;
  logic RST;
  logic BUSY;
  logic DONE;
  logic ERROR;

  expr_tokenizer_if bus_if ();

  expr_tokenizer #(.TERM_CHAR(8'h3D)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .bus   (bus_if),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERROR (ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int totalChecks;
  int badChecks;
  int doneCount;
  int numStbCycles;
  int bothStb;

  logic [8:0] tokens[$];
  logic [8:0] expTok[$];

  function automatic logic [8:0] numTok(input logic [7:0] v);
    return {1'b1, v};
  endfunction

  function automatic logic [8:0] sgnTok(input logic [7:0] c);
    return {1'b0, c};
  endfunction

  // Tokens are tagged with bit 8: 1 = number, 0 = sign.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus_if.NUMBER_STB && bus_if.NUMBER_ACK) tokens.push_back({1'b1, bus_if.NUMBER_OUT});
      if (bus_if.SIGN_STB && bus_if.SIGN_ACK) tokens.push_back({1'b0, bus_if.SIGN_OUT});
      if (bus_if.NUMBER_STB) numStbCycles++;
      if (bus_if.NUMBER_STB && bus_if.SIGN_STB) bothStb++;
      if (DONE) doneCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    @(posedge CLK); #1;
    RST = 1'b1;
    bus_if.CHAR_STB = 1'b0;
    cycles(2);
    RST = 1'b0;
    tokens.delete();
    doneCount = 0;
    numStbCycles = 0;
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) begin
      int waitCnt;
      bit seen;
      bus_if.CHAR_IN  = s[i];
      bus_if.CHAR_STB = 1'b1;
      waitCnt = 0;
      seen = 1'b0;
      while (!seen && waitCnt < 200) begin
        @(negedge CLK);
        seen = bus_if.CHAR_ACK;
        waitCnt++;
      end
      if (!seen) checkOutput($sformatf("char_ack_timeout_%0d", i), 32'(seen), 32'd1);
      @(posedge CLK); #1;
    end
    bus_if.CHAR_STB = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int waitCnt;
    waitCnt = 0;
    while (doneCount == 0 && waitCnt < 200) begin
      @(posedge CLK); #1;
      waitCnt++;
    end
    cycles(5);
    checkOutput({tag, "_done"}, doneCount, 32'd1);
  endtask

  task automatic checkTokens(input string tag);
    checkOutput({tag, "_count"}, tokens.size(), expTok.size());
    for (int i = 0; i < expTok.size(); i++) begin
      logic [8:0] got;
      got = (i < tokens.size()) ? tokens[i] : 9'h000;
      checkOutput($sformatf("%s_tok%0d", tag, i), 32'(got), 32'(expTok[i]));
    end
  endtask

  initial begin
    totalChecks = 0;
    badChecks = 0;
    doneCount = 0;
    numStbCycles = 0;
    bothStb = 0;
    RST = 1'b1;
    bus_if.CHAR_IN = 8'h00;
    bus_if.CHAR_STB = 1'b0;
    bus_if.SIGN_ACK = 1'b1;
    bus_if.NUMBER_ACK = 1'b1;

    // Reset values, including CHAR_ACK suppressed while a character is offered.
    cycles(3);
    bus_if.CHAR_IN = "5";
    bus_if.CHAR_STB = 1'b1;
    #1;
    checkOutput("rst_char_ack", 32'(bus_if.CHAR_ACK), 32'd0);
    checkOutput("rst_number_stb", 32'(bus_if.NUMBER_STB), 32'd0);
    checkOutput("rst_sign_stb", 32'(bus_if.SIGN_STB), 32'd0);
    checkOutput("rst_outs", {16'd0, bus_if.SIGN_OUT, bus_if.NUMBER_OUT}, 32'd0);
    checkOutput("rst_status", {29'd0, BUSY, DONE, ERROR}, 32'd0);
    bus_if.CHAR_STB = 1'b0;
    cycles(1);
    RST = 1'b0;
    cycles(2);
    checkOutput("post_rst_status", {29'd0, BUSY, DONE, ERROR}, 32'd0);

    $display("[TB] expression 12+3=");
    doReset();
    applyStimulus("12+3=");
    waitDone("e1");
    expTok = {numTok(8'd12), sgnTok("+"), numTok(8'd3), sgnTok("=")};
    checkTokens("e1");
    checkOutput("e1_error", 32'(ERROR), 32'd0);

    $display("[TB] expression (4 5)*6=");
    doReset();
    applyStimulus("(4 5)*6=");
    waitDone("e2");
    expTok = {sgnTok("("), numTok(8'd4), numTok(8'd5), sgnTok(")"), sgnTok("*"),
              numTok(8'd6), sgnTok("=")};
    checkTokens("e2");
    checkOutput("e2_error", 32'(ERROR), 32'd0);

    $display("[TB] expression 300= (saturation)");
    doReset();
    applyStimulus("300=");
    waitDone("e3");
    expTok = {numTok(8'd255), sgnTok("=")};
    checkTokens("e3");
    checkOutput("e3_error", 32'(ERROR), 32'd1);
    cycles(10);
    checkOutput("e3_error_sticky", 32'(ERROR), 32'd1);
    doReset();
    checkOutput("e3_error_cleared", 32'(ERROR), 32'd0);

    $display("[TB] expression 7#1+2= (invalid char dropped)");
    doReset();
    applyStimulus("7#1+2=");
    waitDone("e4");
    expTok = {numTok(8'd71), sgnTok("+"), numTok(8'd2), sgnTok("=")};
    checkTokens("e4");
    checkOutput("e4_error", 32'(ERROR), 32'd1);

    $display("[TB] expression 9*2= with number back-pressure");
    doReset();
    bus_if.NUMBER_ACK = 1'b0;
    applyStimulus("9*");
    bus_if.CHAR_IN = "2";
    bus_if.CHAR_STB = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("bp_stb%0d", k), 32'(bus_if.NUMBER_STB), 32'd1);
      checkOutput($sformatf("bp_val%0d", k), 32'(bus_if.NUMBER_OUT), 32'd9);
      checkOutput($sformatf("bp_char_ack%0d", k), 32'(bus_if.CHAR_ACK), 32'd0);
      @(posedge CLK); #1;
    end
    checkOutput("bp_busy", 32'(BUSY), 32'd1);
    bus_if.NUMBER_ACK = 1'b1;
    @(negedge CLK);
    checkOutput("bp_char_ack_last", 32'(bus_if.CHAR_ACK), 32'd0);
    @(posedge CLK); #1;
    checkOutput("bp_stb_cycles", numStbCycles, 32'd6);
    checkOutput("bp_sign_after", {23'd0, bus_if.NUMBER_STB, bus_if.SIGN_OUT}, {23'd0, 1'b0, 8'h2A});
    applyStimulus("2=");
    waitDone("e5");
    expTok = {numTok(8'd9), sgnTok("*"), numTok(8'd2), sgnTok("=")};
    checkTokens("e5");

    $display("[TB] reset during accumulation");
    doReset();
    applyStimulus("4");
    cycles(1);
    checkOutput("r_accum_quiet", {30'd0, BUSY, bus_if.NUMBER_STB}, 32'd0);
    RST = 1'b1;
    cycles(2);
    RST = 1'b0;
    cycles(5);
    checkOutput("r_no_tokens", tokens.size(), 32'd0);
    tokens.delete();
    doneCount = 0;
    applyStimulus("8=");
    waitDone("e6");
    expTok = {numTok(8'd8), sgnTok("=")};
    checkTokens("e6");

    checkOutput("never_both_stb", bothStb, 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
